// File: rtl/divu_multu_sequencer.sv
// Sequencer for the shared iterative multiply/divide unit: clear, ITER iterations, result drain,
// plus HI/LO capture, MTHI/MTLO writes, divide-by-zero and illegal-op reporting.
//   state | meaning
//   IDLE  | ready for a request, HI/LO writable
//   CLEAR | one-cycle clear pulse to the unit
//   RUN   | unit driven with the latched op code for ITER cycles
//   DRAIN | unit commanded to present its result; captured into HI/LO on exit
module divu_multu_sequencer #(
    parameter int          ITER       = 32,
    parameter logic [5:0]  DIVU_CODE  = 6'b011011,
    parameter logic [5:0]  MULTU_CODE = 6'b011001,
    parameter logic [5:0]  OUT_CODE   = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic [5:0]  unit_signal,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_reset,
    input  logic [63:0] unit_result,
    input  logic        wr_hi_en,
    input  logic        wr_lo_en,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        illegal_op
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [5:0]      r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic            r_done;
    logic            r_dbz;
    logic            r_ill;
    logic            w_accept;
    logic            w_op_legal;
    logic            w_div0;
    logic            w_unit_clr;

    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_op_legal = (req_op == DIVU_CODE) || (req_op == MULTU_CODE);
    assign w_div0     = (req_op == DIVU_CODE) && (req_b == 32'd0);

    always_comb begin
        w_state_nxt = r_state;
        unit_signal = 6'd0;
        w_unit_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_op_legal && !w_div0)
                    w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_unit_clr  = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                unit_signal = r_op;
                if (r_cnt == CW'(ITER - 1))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                unit_signal = OUT_CODE;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 6'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_ill   <= w_accept && !w_op_legal;

            if (r_state == S_CLEAR)
                r_cnt <= '0;
            else if (r_state == S_RUN)
                r_cnt <= r_cnt + CW'(1);

            if (w_accept) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
            end

            // Operation results take priority over MTHI/MTLO on the same edge.
            if (r_state == S_DRAIN) begin
                r_hi   <= unit_result[63:32];
                r_lo   <= unit_result[31:0];
                r_done <= 1'b1;
            end else if (w_accept && w_div0) begin
                r_hi   <= req_a;
                r_lo   <= 32'hFFFF_FFFF;
                r_done <= 1'b1;
                r_dbz  <= 1'b1;
            end else if (r_state == S_IDLE) begin
                if (wr_hi_en)
                    r_hi <= wr_data;
                if (wr_lo_en)
                    r_lo <= wr_data;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign unit_reset  = w_unit_clr || reset;
    assign unit_a      = r_a;
    assign unit_b      = r_b;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_ill;

endmodule

// File: tb/tb_divu_multu_sequencer.sv
// Bench for divu_multu_sequencer: behavioural iterative unit, result scoreboard,
// table of single operations plus hand-written multi-cycle sequences.
module tb_divu_multu_sequencer;

    localparam int         ITER  = 32;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] OUTC  = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  req_op = 6'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        req_ready;
    logic [5:0]  unit_signal;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        unit_reset;
    logic [63:0] unit_result;
    logic        wr_hi_en = 1'b0;
    logic        wr_lo_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        illegal_op;

    divu_multu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .unit_signal(unit_signal), .unit_a(unit_a), .unit_b(unit_b),
        .unit_reset(unit_reset), .unit_result(unit_result),
        .wr_hi_en(wr_hi_en), .wr_lo_en(wr_lo_en), .wr_data(wr_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Behavioural unit: only produces a valid result after a clear and exactly ITER cycles of one op.
    int         m_iter;
    logic [5:0] m_op;
    always @(posedge clk) begin
        if (unit_reset) begin
            m_iter <= 0;
            m_op   <= 6'd0;
        end else if (unit_signal == DIVU || unit_signal == MULTU) begin
            m_iter <= m_iter + 1;
            m_op   <= unit_signal;
        end
    end

    always_comb begin
        unit_result = 64'd0;
        if (unit_signal == OUTC) begin
            unit_result = 64'hDEAD_BEEF_DEAD_BEEF;
            if (m_iter == ITER && m_op == MULTU)
                unit_result = {32'd0, unit_a} * {32'd0, unit_b};
            else if (m_iter == ITER && m_op == DIVU && unit_b != 32'd0)
                unit_result = {unit_a % unit_b, unit_a / unit_b};
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;
    exp_t sb[$];

    logic prev_done = 1'b0;
    logic prev_ill  = 1'b0;
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            chk("done_single_pulse", prev_done, 1'b0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("result_dbz", div_by_zero, e.dbz);
            end
        end
        if (!reset && div_by_zero && !done) chk("dbz_without_done", 1'b1, 1'b0);
        if (!reset && illegal_op) chk("illegal_single_pulse", prev_ill, 1'b0);
        prev_done <= done;
        prev_ill  <= illegal_op;
    end

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        ill;
    } vec_t;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic do_op(input vec_t v);
        int cyc = 0;
        int sig_cnt = 0;
        int out_cnt = 0;
        int busy_cnt = 0;
        bit seen = 0;
        @(posedge clk); #1;
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        if (!v.ill) sb.push_back('{v.hi, v.lo, v.dbz});
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.ill) begin
            @(negedge clk);
            chk("illegal_pulse", illegal_op, 1'b1);
            chk("illegal_busy", busy, 1'b0);
            chk("illegal_hi_kept", hi, m_hi);
            chk("illegal_lo_kept", lo, m_lo);
            @(negedge clk);
            chk("illegal_pulse_end", illegal_op, 1'b0);
            return;
        end
        while (cyc < 100) begin
            @(negedge clk);
            if (unit_signal == v.op) sig_cnt++;
            if (unit_signal == OUTC) out_cnt++;
            if (!req_ready) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", seen, 1'b1);
        chk("latency", cyc, v.dbz ? 0 : ITER + 2);
        chk("op_signal_cycles", sig_cnt, v.dbz ? 0 : ITER);
        chk("out_signal_cycles", out_cnt, v.dbz ? 0 : 1);
        chk("not_ready_cycles", busy_cnt, v.dbz ? 0 : ITER + 2);
        m_hi = v.hi;
        m_lo = v.lo;
    endtask

    task automatic wait_sb_empty(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        chk(name, sb.size(), 0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0};
        tbl[1] = '{MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{6'b000001, 32'd3,     32'd4,         32'd1,         32'hFFFF_FFFE, 1'b0, 1'b1};
        tbl[3] = '{DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[4] = '{DIVU,  32'd7,         32'd100,       32'd7,         32'd0,         1'b0, 1'b0};
        tbl[5] = '{MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0, 1'b0};
        tbl[6] = '{DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[7] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_unit_reset", unit_reset, 1'b1);
        chk("rst_unit_signal", unit_signal, 6'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_unit_a", unit_a, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_unit_reset", unit_reset, 1'b0);

        for (int i = 0; i < 8; i++) do_op(tbl[i]);

        // Request held through RUN: not accepted until IDLE, first op's operands undisturbed.
        begin
            int cyc = 0;
            bit stable = 1;
            bit accepted = 0;
            @(posedge clk); #1;
            req_valid = 1'b1; req_op = DIVU; req_a = 32'd100; req_b = 32'd7;
            sb.push_back('{32'd2, 32'd14, 1'b0});
            @(posedge clk); #1;
            req_op = MULTU; req_a = 32'd3; req_b = 32'd4;
            sb.push_back('{32'd0, 32'd12, 1'b0});
            while (cyc < 200) begin
                @(negedge clk);
                if (busy && (unit_a != 32'd100 || unit_b != 32'd7)) stable = 0;
                if (req_ready) begin
                    @(posedge clk); #1;
                    req_valid = 1'b0;
                    accepted = 1;
                    break;
                end
                cyc++;
            end
            chk("held_req_accepted", accepted, 1'b1);
            chk("held_req_wait", cyc, ITER + 2);
            chk("first_operands_stable", stable, 1'b1);
            @(negedge clk);
            chk("second_operand_a", unit_a, 32'd3);
            wait_sb_empty("held_req_results");
            m_hi = 32'd0; m_lo = 32'd12;
        end

        // Reset while RUN counter is 10: abort, HI/LO cleared, no done.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = DIVU; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", done, 1'b0);
        repeat (40) @(posedge clk);
        m_hi = 32'd0; m_lo = 32'd0;
        do_op('{DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0});

        // MTHI / MTLO in IDLE, then ignored while busy.
        @(posedge clk); #1;
        wr_hi_en = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        wr_hi_en = 1'b0;
        @(negedge clk);
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo_kept", lo, 32'd3);
        @(posedge clk); #1;
        wr_hi_en = 1'b1; wr_lo_en = 1'b1; wr_data = 32'h1234_5678;
        @(posedge clk); #1;
        wr_hi_en = 1'b0; wr_lo_en = 1'b0;
        @(negedge clk);
        chk("mthi_mtlo_hi", hi, 32'h1234_5678);
        chk("mthi_mtlo_lo", lo, 32'h1234_5678);

        @(posedge clk); #1;
        req_valid = 1'b1; req_op = MULTU; req_a = 32'd3; req_b = 32'd5;
        sb.push_back('{32'd0, 32'd15, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 wr_hi_en = 1'b1; wr_lo_en = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wr_hi_en = 1'b0; wr_lo_en = 1'b0;
        @(negedge clk);
        chk("busy_write_busy", busy, 1'b1);
        chk("busy_write_hi", hi, 32'h1234_5678);
        chk("busy_write_lo", lo, 32'h1234_5678);
        wait_sb_empty("busy_write_result");

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
